// File: rtl/md5_pkg.sv
// Shared types and constants for the md5 arbiter slice.
// Contents:
//   md5_arb_state_t  - arbiter FSM state encoding
//   MD5_BLOCK_W      - width of one pre-padded message block
//   MD5_DIGEST_W     - width of the core digest
//   MD5_CORE_LATENCY - grant-to-done latency with the team's core, for benches
package md5_pkg;

  localparam int unsigned MD5_BLOCK_W      = 512;
  localparam int unsigned MD5_DIGEST_W     = 128;
  localparam int unsigned MD5_CORE_LATENCY = 69;

  typedef enum logic [2:0] {
    IDLE,
    CORE_RST,
    START,
    BUSY,
    DONE
  } md5_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// The search starts at ptr and wraps modulo NUM_REQ; the first requester found wins.
// The pointer register itself lives in the parent.
// Ports:
//   req  in  NUM_REQ  request vector
//   ptr  in  PtrW     index where the search starts
//   en   in  1        arbitration enable; win is zero when low
//   win  out NUM_REQ  one-hot winner, zero when nothing is requested
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PtrW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PtrW-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] win
);

  logic [PtrW:0]   sum;
  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // One spare bit holds ptr+i before wrapping back into range.
      sum = {1'b0, ptr} + (PtrW + 1)'(i);
      if (sum >= (PtrW + 1)'(NUM_REQ)) begin
        sum = sum - (PtrW + 1)'(NUM_REQ);
      end
      idx = sum[PtrW-1:0];
      if (en && !found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/md5_arbiter.sv
// Round-robin scheduler sharing one md5 compression core between NUM_REQ requesters.
// Each job does the following in order:
//   - resets the core for one cycle;
//   - starts the core for one cycle;
//   - waits for core_ready;
//   - returns the digest to the owner with a one-cycle done pulse.
// Optional feature macro: MD5_ARB_TIMEOUT_EN enables a BUSY watchdog of TIMEOUT cycles
// (TIMEOUT >= 1). A timed-out job completes with err=1 and a zero digest.
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   req             per-requester level request, held until own done
//   req_msg         flattened blocks, requester k at [512*k +: 512]
//   grant           one-hot owner of the core, zero when idle
//   done            one-hot completion pulse
//   err             high together with done on a timed-out job
//   digest_out      digest of the last completed job
//   core_reset      active-high core reset, also asserted while reset_n is low
//   core_start      one-cycle core start
//   core_msg        latched block of the granted requester
//   core_digest     digest from the core
//   core_ready      core completion level
module md5_arbiter
  import md5_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 128
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [512*NUM_REQ-1:0]     req_msg,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       err,
  output logic [MD5_DIGEST_W-1:0]    digest_out,
  output logic                       core_reset,
  output logic                       core_start,
  output logic [MD5_BLOCK_W-1:0]     core_msg,
  input  logic [MD5_DIGEST_W-1:0]    core_digest,
  input  logic                       core_ready
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  md5_arb_state_t           state;
  logic [PtrW-1:0]          ptr_q;
  logic [PtrW-1:0]          gidx_q;
  logic [PtrW-1:0]          ptr_next;
  logic [NUM_REQ-1:0]       win;
  logic [PtrW-1:0]          win_idx;
  logic [MD5_BLOCK_W-1:0]   msg_sel;
  logic                     arb_en;

`ifdef MD5_ARB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CntW-1:0] cnt_q;
  logic            err_q;
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err            = 1'b0;
`endif

  // Requests only compete while idle; anything arriving mid-job waits.
  assign arb_en = (state == IDLE);

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req(req),
    .ptr(ptr_q),
    .en (arb_en),
    .win(win)
  );

  always_comb begin
    win_idx = '0;
    msg_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        win_idx = PtrW'(i);
        msg_sel = req_msg[i*MD5_BLOCK_W +: MD5_BLOCK_W];
      end
    end
  end

  assign ptr_next = (gidx_q == PtrW'(NUM_REQ - 1)) ? '0 : gidx_q + PtrW'(1);

  // The core must reset with the system, hence the combinational reset_n term.
  always_comb begin
    core_reset = (state == CORE_RST) | ~reset_n;
`ifdef MD5_ARB_TIMEOUT_EN
    // Clear a hung core in the same cycle the aborted job is reported.
    if (state == DONE && err_q) begin
      core_reset = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      grant      <= '0;
      done       <= '0;
      core_start <= 1'b0;
      digest_out <= '0;
      core_msg   <= '0;
`ifdef MD5_ARB_TIMEOUT_EN
      err_q      <= 1'b0;
      cnt_q      <= '0;
`endif
    end else begin
      done       <= '0;
      core_start <= 1'b0;
`ifdef MD5_ARB_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (|win) begin
            core_msg <= msg_sel;
            grant    <= win;
            gidx_q   <= win_idx;
            state    <= CORE_RST;
          end
        end
        CORE_RST: begin
          core_start <= 1'b1;
          state      <= START;
        end
        START: begin
`ifdef MD5_ARB_TIMEOUT_EN
          cnt_q <= '0;
`endif
          state <= BUSY;
        end
        BUSY: begin
          if (core_ready) begin
            done       <= grant;
            grant      <= '0;
            digest_out <= core_digest;
            state      <= DONE;
          end
`ifdef MD5_ARB_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            done       <= grant;
            grant      <= '0;
            digest_out <= '0;
            err_q      <= 1'b1;
            state      <= DONE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
`endif
        end
        DONE: begin
          ptr_q <= ptr_next;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_arbiter.sv
// Bench for md5_arbiter with a behavioural md5 core model. Expected digests are RFC 1321
// constants; each job's expectation is queued when its request is driven and checked on done.
module tb_md5_arbiter;
  import md5_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned TIMEOUT = 16;

  localparam logic [127:0] D_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] D_A     = 128'h0cc175b9c0f1b6a831c399e269772661;
  localparam logic [127:0] D_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] D_MD    = 128'hf96b697d7cb7938d525a2f31aaf161d0;

  logic                     clk;
  logic                     reset_n;
  logic [NUM_REQ-1:0]       req;
  logic [512*NUM_REQ-1:0]   req_msg;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     err;
  logic [127:0]             digest_out;
  logic                     core_reset;
  logic                     core_start;
  logic [511:0]             core_msg;
  logic [127:0]             core_digest;
  logic                     core_ready;

  md5_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_msg    (req_msg),
    .grant      (grant),
    .done       (done),
    .err        (err),
    .digest_out (digest_out),
    .core_reset (core_reset),
    .core_start (core_start),
    .core_msg   (core_msg),
    .core_digest(core_digest),
    .core_ready (core_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- md5 reference for the core model ----------------
  logic [31:0] md5_k [64];
  int          md5_s [64];

  initial begin
    real    r;
    longint lv;
    int     j;
    for (int i = 0; i < 64; i++) begin
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      lv = longint'($floor(r * 4294967296.0));
      md5_k[i] = lv[31:0];
      j = i % 4;
      case (i / 16)
        0:       md5_s[i] = (j == 0) ? 7 : (j == 1) ? 12 : (j == 2) ? 17 : 22;
        1:       md5_s[i] = (j == 0) ? 5 : (j == 1) ? 9  : (j == 2) ? 14 : 20;
        2:       md5_s[i] = (j == 0) ? 4 : (j == 1) ? 11 : (j == 2) ? 16 : 23;
        default: md5_s[i] = (j == 0) ? 6 : (j == 1) ? 10 : (j == 2) ? 15 : 21;
      endcase
    end
  end

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Message byte j sits at blk[511-8*j -: 8]; digest byte 0 at [127:120].
  function automatic logic [127:0] md5_block(input logic [511:0] blk);
    logic [31:0] m [16];
    logic [31:0] a, b, c, d, f;
    int          g;
    for (int w = 0; w < 16; w++) begin
      m[w] = bswap(blk[511-32*w -: 32]);
    end
    a = 32'h67452301;
    b = 32'hefcdab89;
    c = 32'h98badcfe;
    d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      if (i < 16) begin
        f = (b & c) | (~b & d);
        g = i;
      end else if (i < 32) begin
        f = (d & b) | (~d & c);
        g = (5 * i + 1) % 16;
      end else if (i < 48) begin
        f = b ^ c ^ d;
        g = (3 * i + 5) % 16;
      end else begin
        f = c ^ (b | ~d);
        g = (7 * i) % 16;
      end
      f = f + a + md5_k[i] + m[g];
      a = d;
      d = c;
      c = b;
      b = b + ((f << md5_s[i]) | (f >> (32 - md5_s[i])));
    end
    a = a + 32'h67452301;
    b = b + 32'hefcdab89;
    c = c + 32'h98badcfe;
    d = d + 32'h10325476;
    return {bswap(a), bswap(b), bswap(c), bswap(d)};
  endfunction

  function automatic logic [511:0] pad_msg(input string s);
    logic [511:0] blk;
    logic [15:0]  bits;
    int           n;
    blk  = '0;
    n    = s.len();
    for (int j = 0; j < n; j++) blk[511-8*j -: 8] = s[j];
    blk[511-8*n -: 8] = 8'h80;
    bits = 16'(n * 8);
    blk[511-8*56 -: 8] = bits[7:0];
    blk[511-8*57 -: 8] = bits[15:8];
    return blk;
  endfunction

  // ---------------- core model ----------------
  logic stall = 1'b0;
  logic running = 1'b0;
  int   ccnt = 0;

  initial begin
    core_ready  = 1'b0;
    core_digest = '0;
  end

  // Start is sampled on edge 2 of a job; ready is seen by the arbiter on edge 69.
  always @(posedge clk) begin
    if (core_reset) begin
      running    <= 1'b0;
      core_ready <= 1'b0;
      ccnt       <= 0;
    end else if (core_start) begin
      running     <= 1'b1;
      ccnt        <= 0;
      core_digest <= md5_block(core_msg);
    end else if (running) begin
      ccnt <= ccnt + 1;
      if (ccnt == int'(MD5_CORE_LATENCY) - 4 && !stall) core_ready <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int           idx;
    logic [127:0] dig;
    logic         err;
    int           lat;
    logic [511:0] msg;
  } exp_t;

  exp_t sb[$];

  task automatic expect_job(input int k, input logic [511:0] msg, input logic [127:0] dig,
                            input logic e, input int lat);
    exp_t x;
    x.idx = k;
    x.msg = msg;
    x.dig = dig;
    x.err = e;
    x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic request(input int k, input string s, input logic [127:0] dig,
                         input logic e, input int lat);
    req_msg[512*k +: 512] = pad_msg(s);
    req[k] = 1'b1;
    expect_job(k, pad_msg(s), dig, e, lat);
  endtask

  // ---------------- output monitor ----------------
  logic [NUM_REQ-1:0] prev_gnt = '0;
  logic [127:0]       last_dig = '0;
  int                 grant_cyc = 0;
  int                 start_cyc = 0;
  int                 nstart = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_gnt = '0;
      last_dig = '0;
      nstart   = 0;
    end else begin
      if (grant != '0 && prev_gnt == '0) begin
        grant_cyc = cyc;
        nstart    = 0;
        if (sb.size() == 0) begin
          check_eq("grant_unexpected", grant, 0);
        end else begin
          check_eq("grant_owner", grant, 512'(1) << sb[0].idx);
          check_eq("core_msg", core_msg, sb[0].msg);
          check_eq("digest_hold", digest_out, last_dig);
        end
      end
      if (core_start) begin
        nstart++;
        start_cyc = cyc;
      end
      if (done != '0) begin
        if (sb.size() == 0) begin
          check_eq("done_unexpected", done, 0);
        end else begin
          e = sb.pop_front();
          check_eq("done_owner", done, 512'(1) << e.idx);
          check_eq("digest_out", digest_out, e.dig);
          check_eq("err", err, e.err);
          check_eq("core_reset_in_done", core_reset, e.err);
          check_eq("grant_cleared", grant, 0);
          check_eq("latency", cyc - grant_cyc, e.lat);
          check_eq("start_offset", start_cyc - grant_cyc, 1);
          check_eq("start_pulses", nstart, 1);
        end
        last_dig = digest_out;
      end
      prev_gnt = grant;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_grant(input int budget);
    int n = 0;
    while (grant == '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("grant_wait", grant != '0, 1);
  endtask

  // Waits for n completions; requesters not in keep drop req on their own done.
  task automatic run_jobs(input int n, input logic [NUM_REQ-1:0] keep);
    int w;
    for (int j = 0; j < n; j++) begin
      w = 0;
      @(negedge clk);
      while (done == '0 && w < 200) begin
        @(negedge clk);
        w++;
      end
      check_eq("done_wait", done != '0, 1);
      req = req & ~(done & ~keep);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam int Lat = int'(MD5_CORE_LATENCY);

  initial begin
    req     = '0;
    req_msg = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check_eq("rst_grant", grant, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_core_start", core_start, 0);
    check_eq("rst_digest", digest_out, 0);
    check_eq("rst_core_msg", core_msg, 0);
    check_eq("rst_core_reset", core_reset, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single request, empty message.
    request(0, "", D_EMPTY, 1'b0, Lat);
    run_jobs(1, '0);

    // Contention: three requests in the same cycle, pointer at 1.
    request(1, "a", D_A, 1'b0, Lat);
    request(2, "abc", D_ABC, 1'b0, Lat);
    request(3, "message digest", D_MD, 1'b0, Lat);
    run_jobs(3, '0);

    // Fairness: req[0] held, req[2] arrives mid-job -> 0, 2, 0.
    request(0, "", D_EMPTY, 1'b0, Lat);
    wait_grant(10);
    request(2, "a", D_A, 1'b0, Lat);
    expect_job(0, pad_msg(""), D_EMPTY, 1'b0, Lat);
    run_jobs(2, 4'b0001);
    run_jobs(1, '0);

    // Reset during BUSY: job lost, outputs clear at once, pointer back to 0.
    request(2, "message digest", D_MD, 1'b0, Lat);
    wait_grant(10);
    repeat (10) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_eq("midrst_grant", grant, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_err", err, 0);
    check_eq("midrst_core_start", core_start, 0);
    check_eq("midrst_digest", digest_out, 0);
    check_eq("midrst_core_msg", core_msg, 0);
    check_eq("midrst_core_reset", core_reset, 1);
    sb.delete();
    req = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    request(0, "abc", D_ABC, 1'b0, Lat);
    request(3, "a", D_A, 1'b0, Lat);
    run_jobs(2, '0);

`ifdef MD5_ARB_TIMEOUT_EN
    // Core never ready: abort after TIMEOUT BUSY cycles, then serve normally.
    stall = 1'b1;
    request(1, "", 128'h0, 1'b1, int'(TIMEOUT) + 2);
    run_jobs(1, '0);
    stall = 1'b0;
    request(1, "abc", D_ABC, 1'b0, Lat);
    run_jobs(1, '0);
`endif

    repeat (5) @(negedge clk);
    check_eq("scoreboard_drained", sb.size(), 0);
    check_eq("idle_grant", grant, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
